// File: rtl/gpu_core_pkg.sv
// Shared GPU core definitions: pipeline stage encoding, NZP flag layout and
// default datapath widths used by the ALU, scheduler, decoder and PC unit.
package gpu_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_e;

  localparam int N_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int P_BIT = 0;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_ADDR_BITS = 8;

  // True when any stored flag is selected by the branch mask.
  function automatic logic nzp_match(input logic [2:0] flags, input logic [2:0] mask);
    return (flags[N_BIT] & mask[N_BIT]) |
           (flags[Z_BIT] & mask[Z_BIT]) |
           (flags[P_BIT] & mask[P_BIT]);
  endfunction

endpackage

// File: rtl/pc_call_stack.sv
// Return-address LIFO for the PC unit. Pushes when full and pops when empty
// are ignored here; the caller flags them as errors.
module pc_call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top_data
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] sp_r;
  logic [PTR_W-1:0] top_ptr_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full      = (sp_r == PTR_W'(DEPTH));
  assign empty     = (sp_r == PTR_W'(0));
  assign top_ptr_s = sp_r - PTR_W'(1);
  assign top_data  = mem_r[top_ptr_s[IDX_W-1:0]];

  // Stack pointer: counts valid entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r <= PTR_W'(0);
    end else if (push && !full) begin
      sp_r <= sp_r + PTR_W'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - PTR_W'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage; contents need no reset because sp_r bounds every read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[sp_r[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_nzp_unit.sv
// Per-thread PC and NZP condition unit, updated in the UPDATE stage.
// Optional subroutine call/return stack enabled by PC_CALL_STACK_EN.
module pc_nzp_unit
  import gpu_core_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic                 dec_nzp_write_en,
  input  logic                 dec_pc_mux,
  input  logic [2:0]           dec_nzp_mask,
  input  logic [DATA_BITS-1:0] dec_imm,
  input  logic                 dec_halt,
  input  logic                 dec_call,
  input  logic                 dec_return,
  output logic [ADDR_BITS-1:0] pc,
  output logic [2:0]           nzp,
  output logic                 done,
  output logic                 branch_taken,
  output logic                 stack_err
);

  localparam int EXT_W = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;

  logic [ADDR_BITS-1:0] pc_r, pc_next_s, pc_inc_s, target_s, stack_top_s;
  logic [EXT_W-1:0]     imm_ext_s;
  logic [2:0]           nzp_r, nzp_next_s;
  logic                 done_r, done_next_s;
  logic                 bt_r, bt_next_s;
  logic                 stack_err_r, serr_next_s;
  logic                 update_s, branch_s, call_s, return_s;
  logic                 push_s, pop_s, stack_full_s, stack_empty_s;

  assign update_s  = enable && (core_state == ST_UPDATE) && !done_r;
  assign imm_ext_s = EXT_W'(dec_imm);
  assign target_s  = imm_ext_s[ADDR_BITS-1:0];
  assign pc_inc_s  = pc_r + ADDR_BITS'(1'b1);
  // The branch looks at the stored flags, so a CMP in the same instruction
  // only affects later branches.
  assign branch_s  = dec_pc_mux && nzp_match(nzp_r, dec_nzp_mask);

`ifdef PC_CALL_STACK_EN
  assign call_s   = dec_call;
  assign return_s = dec_return;

  pc_call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_BITS)
  ) u_call_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .full      (stack_full_s),
    .empty     (stack_empty_s),
    .top_data  (stack_top_s)
  );

  assign stack_err = stack_err_r;

  logic unused_s;
  assign unused_s = &{1'b0, alu_out[DATA_BITS-1:3]};
`else
  localparam int unused_depth = STACK_DEPTH;

  assign call_s        = 1'b0;
  assign return_s      = 1'b0;
  assign stack_full_s  = 1'b0;
  assign stack_empty_s = 1'b1;
  assign stack_top_s   = {ADDR_BITS{1'b0}};
  assign stack_err     = 1'b0;

  logic unused_s;
  assign unused_s = &{1'b0, alu_out[DATA_BITS-1:3], dec_call, dec_return,
                      push_s, pop_s, stack_err_r};
`endif

  // Next-state selection: halt > return > call > branch > increment.
  always_comb begin
    pc_next_s   = pc_r;
    nzp_next_s  = nzp_r;
    done_next_s = done_r;
    bt_next_s   = 1'b0;
    serr_next_s = stack_err_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (update_s) begin
      if (dec_nzp_write_en) begin
        nzp_next_s = alu_out[2:0];
      end else begin
        nzp_next_s = nzp_r;
      end
      if (dec_halt) begin
        done_next_s = 1'b1;
      end else if (return_s) begin
        if (stack_empty_s) begin
          pc_next_s   = pc_inc_s;
          serr_next_s = 1'b1;
        end else begin
          pop_s     = 1'b1;
          pc_next_s = stack_top_s;
          bt_next_s = 1'b1;
        end
      end else if (call_s) begin
        pc_next_s = target_s;
        bt_next_s = 1'b1;
        if (stack_full_s) begin
          serr_next_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end else if (branch_s) begin
        pc_next_s = target_s;
        bt_next_s = 1'b1;
      end else begin
        pc_next_s = pc_inc_s;
      end
    end else begin
      pc_next_s   = pc_r;
      nzp_next_s  = nzp_r;
      done_next_s = done_r;
    end
  end

  // State registers; reset overrides any concurrent UPDATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= {ADDR_BITS{1'b0}};
      nzp_r       <= 3'b000;
      done_r      <= 1'b0;
      bt_r        <= 1'b0;
      stack_err_r <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      nzp_r       <= nzp_next_s;
      done_r      <= done_next_s;
      bt_r        <= bt_next_s;
      stack_err_r <= serr_next_s;
    end
  end

  assign pc           = pc_r;
  assign nzp          = nzp_r;
  assign done         = done_r;
  assign branch_taken = bt_r;

endmodule

// File: tb/tb_pc_nzp_unit.sv
// Self-checking bench for pc_nzp_unit against a queue-based reference model.
module tb_pc_nzp_unit;

  localparam logic [2:0] ST_UPD = 3'd6;
  localparam logic [2:0] ST_EXE = 3'd5;
  localparam int DEPTH = 4;
`ifdef PC_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, dec_nzp_write_en, dec_pc_mux, dec_halt, dec_call, dec_return;
  logic [2:0] core_state, dec_nzp_mask;
  logic [7:0] alu_out, dec_imm;
  logic [7:0] pc;
  logic [2:0] nzp;
  logic       done, branch_taken, stack_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc;
  logic [2:0] m_nzp;
  logic       m_done, m_bt, m_serr;
  logic [7:0] m_stack[$];

  pc_nzp_unit #(.DATA_BITS(8), .ADDR_BITS(8), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .alu_out(alu_out), .dec_nzp_write_en(dec_nzp_write_en), .dec_pc_mux(dec_pc_mux),
    .dec_nzp_mask(dec_nzp_mask), .dec_imm(dec_imm), .dec_halt(dec_halt),
    .dec_call(dec_call), .dec_return(dec_return), .pc(pc), .nzp(nzp), .done(done),
    .branch_taken(branch_taken), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input logic r, input logic en, input logic [2:0] st,
                      input logic [7:0] alu, input logic cmp, input logic br,
                      input logic [2:0] mask, input logic [7:0] imm,
                      input logic halt, input logic call, input logic ret);
    logic [2:0] old_nzp;
    reset = r; enable = en; core_state = st; alu_out = alu;
    dec_nzp_write_en = cmp; dec_pc_mux = br; dec_nzp_mask = mask; dec_imm = imm;
    dec_halt = halt; dec_call = call; dec_return = ret;
    @(posedge clk);
    m_bt = 1'b0;
    if (r) begin
      m_pc = 8'd0; m_nzp = 3'b000; m_done = 1'b0; m_serr = 1'b0;
      m_stack.delete();
    end else if (en && st == ST_UPD && !m_done) begin
      old_nzp = m_nzp;
      if (cmp) m_nzp = alu[2:0];
      if (halt) begin
        m_done = 1'b1;
      end else if (STACK_EN && ret) begin
        if (m_stack.size() == 0) begin
          m_pc = m_pc + 8'd1; m_serr = 1'b1;
        end else begin
          m_pc = m_stack.pop_back(); m_bt = 1'b1;
        end
      end else if (STACK_EN && call) begin
        if (m_stack.size() >= DEPTH) m_serr = 1'b1;
        else m_stack.push_back(m_pc + 8'd1);
        m_pc = imm; m_bt = 1'b1;
      end else if (br && (old_nzp & mask) != 3'b000) begin
        m_pc = imm; m_bt = 1'b1;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
    #1;
  endtask

  task automatic plain_update();
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, ST_UPD, 8'hFF, 1'b1, 1'b1, 3'b111, 8'h55, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({pc, nzp, done, branch_taken, stack_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset: got pc=%h nzp=%b done=%b bt=%b err=%b want all zero",
               pc, nzp, done, branch_taken, stack_err);
    end
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      plain_update();
      checks++;
      if (pc !== 8'(i) || nzp !== 3'b000 || done !== 1'b0 || branch_taken !== 1'b0) begin
        errors++;
        $display("FAIL increment %0d: got pc=%h nzp=%b done=%b bt=%b want pc=%h nzp=000 done=0 bt=0",
                 i, pc, nzp, done, branch_taken, 8'(i));
      end
    end
  endtask

  task automatic test_cmp_branch();
    step(1'b0, 1'b1, ST_UPD, 8'h04, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (nzp !== 3'b100 || pc !== m_pc) begin
      errors++;
      $display("FAIL cmp_latch: got nzp=%b pc=%h want nzp=100 pc=%h", nzp, pc, m_pc);
    end
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b1, 3'b100, 8'h20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'h20 || branch_taken !== 1'b1) begin
      errors++;
      $display("FAIL branch_taken: got pc=%h bt=%b want pc=20 bt=1", pc, branch_taken);
    end
    step(1'b0, 1'b1, ST_EXE, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (branch_taken !== 1'b0 || pc !== 8'h20) begin
      errors++;
      $display("FAIL bt_pulse_width: got pc=%h bt=%b want pc=20 bt=0", pc, branch_taken);
    end
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b1, 3'b011, 8'h40, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'h21 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken: got pc=%h bt=%b want pc=21 bt=0", pc, branch_taken);
    end
  endtask

  task automatic test_same_instr();
    step(1'b0, 1'b1, ST_UPD, 8'h02, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, ST_UPD, 8'h01, 1'b1, 1'b1, 3'b001, 8'h40, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== m_pc || nzp !== 3'b001 || branch_taken !== 1'b0 || m_pc === 8'h40) begin
      errors++;
      $display("FAIL old_nzp_branch: got pc=%h nzp=%b bt=%b want pc=%h nzp=001 bt=0",
               pc, nzp, branch_taken, m_pc);
    end
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b1, 3'b001, 8'h40, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'h40 || branch_taken !== 1'b1) begin
      errors++;
      $display("FAIL new_nzp_branch: got pc=%h bt=%b want pc=40 bt=1", pc, branch_taken);
    end
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b1, 3'b000, 8'h60, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'h41 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL mask_000: got pc=%h bt=%b want pc=41 bt=0", pc, branch_taken);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b1, 3'b111, 8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'hFF) begin
      errors++;
      $display("FAIL mask_111: got pc=%h want pc=ff", pc);
    end
    plain_update();
    checks++;
    if (pc !== 8'h00 || pc !== m_pc) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h want pc=00", pc);
    end
  endtask

  task automatic test_hold();
    logic [7:0] pc_before;
    logic [2:0] nzp_before;
    plain_update();
    pc_before = m_pc; nzp_before = m_nzp;
    step(1'b0, 1'b0, ST_UPD, 8'h04, 1'b1, 1'b1, 3'b111, 8'h77, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== pc_before || nzp !== nzp_before || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL hold_disabled: got pc=%h nzp=%b bt=%b want pc=%h nzp=%b bt=0",
               pc, nzp, branch_taken, pc_before, nzp_before);
    end
    step(1'b0, 1'b1, ST_EXE, 8'h04, 1'b1, 1'b1, 3'b111, 8'h77, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== pc_before || nzp !== nzp_before || done !== 1'b0 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL hold_execute: got pc=%h nzp=%b done=%b bt=%b want pc=%h nzp=%b done=0 bt=0",
               pc, nzp, done, branch_taken, pc_before, nzp_before);
    end
  endtask

  task automatic test_halt();
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) plain_update();
    step(1'b0, 1'b1, ST_UPD, 8'h04, 1'b1, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'h05 || done !== 1'b1 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL halt: got pc=%h done=%b bt=%b want pc=05 done=1 bt=0", pc, done, branch_taken);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, ST_UPD, 8'h01, 1'b1, 1'b1, 3'b111, 8'h90, 1'b0, 1'b0, 1'b0);
      checks++;
      if (pc !== 8'h05 || done !== 1'b1 || nzp !== m_nzp || branch_taken !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky %0d: got pc=%h done=%b nzp=%b bt=%b want pc=05 done=1 nzp=%b bt=0",
                 i, pc, done, nzp, branch_taken, m_nzp);
      end
    end
    step(1'b1, 1'b1, ST_UPD, 8'h04, 1'b1, 1'b1, 3'b111, 8'h33, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 8'h00 || done !== 1'b0 || nzp !== 3'b000 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_update: got pc=%h done=%b nzp=%b bt=%b want pc=00 done=0 nzp=000 bt=0",
               pc, done, nzp, branch_taken);
    end
  endtask

  task automatic test_call_stack();
    logic [7:0] targets [5];
    logic [7:0] rets [4];
    targets = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    rets    = '{8'h31, 8'h21, 8'h11, 8'h01};
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b0, 3'b000, targets[i], 1'b0, 1'b1, 1'b0);
      checks++;
      if (pc !== targets[i] || branch_taken !== 1'b1 || stack_err !== (i == 4)) begin
        errors++;
        $display("FAIL call %0d: got pc=%h bt=%b err=%b want pc=%h bt=1 err=%b",
                 i, pc, branch_taken, stack_err, targets[i], (i == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (pc !== rets[i] || branch_taken !== 1'b1 || stack_err !== 1'b1) begin
        errors++;
        $display("FAIL return %0d: got pc=%h bt=%b err=%b want pc=%h bt=1 err=1",
                 i, pc, branch_taken, stack_err, rets[i]);
      end
    end
    step(1'b0, 1'b1, ST_UPD, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pc !== 8'h02 || branch_taken !== 1'b0 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL return_empty: got pc=%h bt=%b err=%b want pc=02 bt=0 err=1",
               pc, branch_taken, stack_err);
    end
  endtask

  task automatic test_random();
    logic r, en, halt;
    logic [2:0] st;
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 79) == 0);
      en   = ($urandom_range(0, 9) != 0);
      st   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : ST_UPD;
      halt = ($urandom_range(0, 49) == 0);
      step(r, en, st, 8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
           8'($urandom), halt, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      checks++;
      if ({pc, nzp, done, branch_taken, stack_err} !== {m_pc, m_nzp, m_done, m_bt, m_serr}) begin
        errors++;
        $display("FAIL random %0d: got pc=%h nzp=%b done=%b bt=%b err=%b want pc=%h nzp=%b done=%b bt=%b err=%b",
                 i, pc, nzp, done, branch_taken, stack_err, m_pc, m_nzp, m_done, m_bt, m_serr);
      end
    end
  endtask

  initial begin
    m_pc = 8'd0; m_nzp = 3'b000; m_done = 1'b0; m_bt = 1'b0; m_serr = 1'b0;
    test_reset();
    test_increment();
    test_cmp_branch();
    test_same_instr();
    test_wrap();
    test_hold();
    test_halt();
    if (STACK_EN) test_call_stack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
